// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - cache miss / store / memory / fill signal bundle for cache_fill_fsm
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
);
  localparam int OFF_W = $clog2(WORDS);

  logic              i_miss;
  logic [ADDR_W-1:0] i_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_addr;
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [15:0]       st_data;
  logic              mem_data_valid;
  logic [15:0]       mem_data_in;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data_out;
  logic [15:0]       fill_data;
  logic [OFF_W-1:0]  fill_word;
  logic              fill_wr_i;
  logic              fill_wr_d;
  logic              tag_wr_i;
  logic              tag_wr_d;
  logic              stall;

  // master is the fill controller, slave is the caches/memory/pipeline side
  modport master (
    input  i_miss, i_addr, d_miss, d_addr, st_req, st_addr, st_data,
           mem_data_valid, mem_data_in,
    output mem_en, mem_wr, mem_addr, mem_data_out, fill_data, fill_word,
           fill_wr_i, fill_wr_d, tag_wr_i, tag_wr_d, stall
  );

  modport slave (
    output i_miss, i_addr, d_miss, d_addr, st_req, st_addr, st_data,
           mem_data_valid, mem_data_in,
    input  mem_en, mem_wr, mem_addr, mem_data_out, fill_data, fill_word,
           fill_wr_i, fill_wr_d, tag_wr_i, tag_wr_d, stall
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - shared I/D cache miss fill controller with write-through store forwarding
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_fill_fsm_if.master bus
);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int BASE_W = ADDR_W - OFF_W - 1;
  localparam logic [OFF_W:0] LAST = (OFF_W + 1)'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL_D, FILL_I, DRAIN} state_t;

  state_t            state, state_n;
  logic [BASE_W-1:0] base, base_n;
  logic [OFF_W:0]    req_cnt, req_cnt_n;
  logic [OFF_W:0]    rcv_cnt, rcv_cnt_n;
  logic              src_i, src_i_n;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[OFF_W:0], bus.d_addr[OFF_W:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
      src_i   <= 1'b0;
    end else begin
      state   <= state_n;
      base    <= base_n;
      req_cnt <= req_cnt_n;
      rcv_cnt <= rcv_cnt_n;
      src_i   <= src_i_n;
    end
  end

  always_comb begin
    state_n          = state;
    base_n           = base;
    req_cnt_n        = req_cnt;
    rcv_cnt_n        = rcv_cnt;
    src_i_n          = src_i;
    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data_out = '0;
    bus.fill_data    = '0;
    bus.fill_word    = '0;
    bus.fill_wr_i    = 1'b0;
    bus.fill_wr_d    = 1'b0;
    bus.tag_wr_i     = 1'b0;
    bus.tag_wr_d     = 1'b0;

    unique case (state)
      IDLE: begin
        // the store uses the port this cycle; a pending miss is latched alongside it
        if (bus.st_req) begin
          bus.mem_en       = 1'b1;
          bus.mem_wr       = 1'b1;
          bus.mem_addr     = bus.st_addr;
          bus.mem_data_out = bus.st_data;
        end
        if (bus.d_miss) begin
          base_n  = bus.d_addr[ADDR_W-1 -: BASE_W];
          src_i_n = 1'b0;
          state_n = FILL_D;
        end else if (bus.i_miss) begin
          base_n  = bus.i_addr[ADDR_W-1 -: BASE_W];
          src_i_n = 1'b1;
          state_n = FILL_I;
        end
      end
      FILL_D, FILL_I: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = {base, req_cnt[OFF_W-1:0], 1'b0};
        req_cnt_n    = req_cnt + 1'b1;
        if (req_cnt == LAST) state_n = DRAIN;
      end
      default: ;
    endcase

    // returned words are counted rather than timed, so memory latency is not baked in
    if (state != IDLE && bus.mem_data_valid) begin
      bus.fill_data = bus.mem_data_in;
      bus.fill_word = rcv_cnt[OFF_W-1:0];
      bus.fill_wr_i = src_i;
      bus.fill_wr_d = !src_i;
      rcv_cnt_n     = rcv_cnt + 1'b1;
      if (rcv_cnt == LAST) begin
        bus.tag_wr_i = src_i;
        bus.tag_wr_d = !src_i;
        req_cnt_n    = '0;
        rcv_cnt_n    = '0;
        state_n      = IDLE;
      end
    end

    bus.stall = (state != IDLE) | bus.i_miss | bus.d_miss;
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - scoreboard bench for cache_fill_fsm with a timeline reference model
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  cache_fill_fsm_if #(.ADDR_W(16), .WORDS(8)) bus ();

  cache_fill_fsm #(.WORDS(8), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] d;
    logic        s;
    logic [2:0]  w;
  } ev_t;

  ev_t exp_rd[$];
  ev_t exp_st[$];
  ev_t exp_fill[$];
  ev_t exp_tag[$];
  ev_t pend[$];

  function automatic ev_t mk(input int c, input logic [15:0] a, input logic [15:0] d,
                             input logic s, input logic [2:0] w);
    ev_t e;
    e.cyc = c; e.a = a; e.d = d; e.s = s; e.w = w;
    return e;
  endfunction

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // a miss seen in IDLE at cycle c0: reads c0+1..c0+8, data c0+5..c0+12, tag at c0+12
  task automatic push_block(input logic s, input logic [15:0] addr, input int c0);
    logic [15:0] b;
    b = {addr[15:4], 4'h0};
    for (int k = 0; k < 8; k++) begin
      exp_rd.push_back(mk(c0 + 1 + k, b + 16'(2 * k), 16'h0, s, 3'(k)));
      exp_fill.push_back(mk(c0 + 5 + k, b + 16'(2 * k), memf(b + 16'(2 * k)), s, 3'(k)));
    end
    exp_tag.push_back(mk(c0 + 12, b, 16'h0, s, 3'h0));
  endtask

  // memory: answers each read exactly four cycles after it is issued
  initial begin
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (pend.size() > 0 && pend[0].cyc == cyc) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in    = memf(pend[0].a);
        void'(pend.pop_front());
      end else begin
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = 16'($urandom);
      end
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_en && !bus.mem_wr) begin
        pend.push_back(mk(cyc + 4, bus.mem_addr, 16'h0, 1'b0, 3'h0));
        if (exp_rd.size() == 0) chk(1'b0, "read_unexpected", 64'(bus.mem_addr), 64'h0);
        else begin
          e = exp_rd.pop_front();
          chk(e.cyc == cyc && e.a == bus.mem_addr, "read",
              64'({cyc, bus.mem_addr}), 64'({e.cyc, e.a}));
        end
      end
      if (bus.mem_en && bus.mem_wr) begin
        if (exp_st.size() == 0) chk(1'b0, "store_unexpected", 64'(bus.mem_addr), 64'h0);
        else begin
          e = exp_st.pop_front();
          chk(e.cyc == cyc && e.a == bus.mem_addr && e.d == bus.mem_data_out, "store",
              64'({cyc, bus.mem_addr, bus.mem_data_out}), 64'({e.cyc, e.a, e.d}));
        end
      end
      if (bus.fill_wr_i || bus.fill_wr_d) begin
        if (exp_fill.size() == 0)
          chk(1'b0, "fill_unexpected", 64'({bus.fill_wr_i, bus.fill_wr_d, bus.fill_word}), 64'h0);
        else begin
          e = exp_fill.pop_front();
          chk(e.cyc == cyc && bus.fill_wr_i == e.s && bus.fill_wr_d == !e.s && !bus.mem_wr &&
              bus.fill_word == e.w && bus.fill_data == e.d, "fill",
              64'({cyc, bus.fill_wr_i, bus.fill_wr_d, bus.mem_wr, bus.fill_word, bus.fill_data}),
              64'({e.cyc, e.s, !e.s, 1'b0, e.w, e.d}));
        end
      end
      if (bus.tag_wr_i || bus.tag_wr_d) begin
        if (exp_tag.size() == 0) chk(1'b0, "tag_unexpected", 64'({bus.tag_wr_i, bus.tag_wr_d}), 64'h0);
        else begin
          e = exp_tag.pop_front();
          chk(e.cyc == cyc && bus.tag_wr_i == e.s && bus.tag_wr_d == !e.s, "tag",
              64'({cyc, bus.tag_wr_i, bus.tag_wr_d}), 64'({e.cyc, e.s, !e.s}));
        end
      end
    end
  end

  task automatic run_txn(input bit has_d, input bit has_i, input bit has_st, input bit withdraw,
                         input logic [15:0] da, input logic [15:0] ia,
                         input logic [15:0] sa, input logic [15:0] sd);
    int c, len, d_drop, stall_n;
    @(posedge clk); #1;
    c = cyc;
    rst_n = 1'b1;
    bus.d_miss = has_d; bus.d_addr = da;
    bus.i_miss = has_i; bus.i_addr = ia;
    bus.st_req = has_st; bus.st_addr = sa; bus.st_data = sd;
    if (has_st) exp_st.push_back(mk(c, sa, sd, 1'b0, 3'h0));
    if (has_d) push_block(1'b0, da, c);
    if (has_i) push_block(1'b1, ia, has_d ? c + 13 : c);
    len = (has_d ? 13 : 0) + (has_i ? 13 : 0);
    d_drop = withdraw ? 3 : 13;
    stall_n = 0;
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      if (bus.stall) stall_n++;
      @(posedge clk); #1;
      bus.st_req = 1'b0;
      if (k + 1 == d_drop) bus.d_miss = 1'b0;
      if (k + 1 == len) bus.i_miss = 1'b0;
    end
    chk(stall_n == len, "stall_cycles", 64'(stall_n), 64'(len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int kind, c;
    bus.i_miss = 1'b0; bus.i_addr = 16'h0;
    bus.d_miss = 1'b1; bus.d_addr = 16'h1236;
    bus.st_req = 1'b0; bus.st_addr = 16'h0; bus.st_data = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_data_out, bus.fill_data, bus.fill_word,
         bus.fill_wr_i, bus.fill_wr_d, bus.tag_wr_i, bus.tag_wr_d} == '0, "reset_outputs",
        64'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.fill_wr_i, bus.fill_wr_d, bus.tag_wr_i,
             bus.tag_wr_d}), 64'h0);
    chk(bus.stall == 1'b1, "reset_stall", 64'(bus.stall), 64'h1);

    run_txn(1, 0, 0, 0, 16'h1236, 16'h0, 16'h0, 16'h0);
    run_txn(1, 1, 0, 0, 16'h8000, 16'h0040, 16'h0, 16'h0);
    run_txn(1, 0, 1, 0, 16'h4a52, 16'h0, 16'h0200, 16'hBEEF);
    run_txn(1, 0, 0, 1, 16'h7777, 16'h0, 16'h0, 16'h0);
    run_txn(0, 0, 1, 0, 16'h0, 16'h0, 16'hFFFE, 16'h1234);
    run_txn(0, 1, 0, 0, 16'h0, 16'hFFFF, 16'h0, 16'h0);

    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: run_txn(1, 0, 0, 0, 16'($urandom), 16'h0, 16'h0, 16'h0);
        1: run_txn(0, 1, 0, 0, 16'h0, 16'($urandom), 16'h0, 16'h0);
        2: run_txn(1, 1, 0, 0, 16'($urandom), 16'($urandom), 16'h0, 16'h0);
        3: run_txn(1, 0, 1, 0, 16'($urandom), 16'h0, 16'($urandom), 16'($urandom));
        4: run_txn(0, 0, 1, 0, 16'h0, 16'h0, 16'($urandom), 16'($urandom));
        5: run_txn(1, 0, 0, 1, 16'($urandom), 16'h0, 16'h0, 16'h0);
        default: run_txn(0, 1, 1, 0, 16'h0, 16'($urandom), 16'($urandom), 16'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // reset after three words have landed: no tag, late data must not be written
    @(posedge clk); #1;
    c = cyc;
    bus.d_miss = 1'b1;
    bus.d_addr = 16'h5a5a;
    for (int k = 0; k < 7; k++)
      exp_rd.push_back(mk(c + 1 + k, 16'h5a50 + 16'(2 * k), 16'h0, 1'b0, 3'(k)));
    for (int k = 0; k < 3; k++)
      exp_fill.push_back(mk(c + 5 + k, 16'h5a50 + 16'(2 * k), memf(16'h5a50 + 16'(2 * k)), 1'b0, 3'(k)));
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.d_miss = 1'b0;
    @(negedge clk);
    chk(bus.stall == 1'b0 && bus.mem_en == 1'b0, "reset_midfill_idle",
        64'({bus.stall, bus.mem_en}), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    chk(exp_rd.size() == 0 && exp_fill.size() == 0 && exp_tag.size() == 0, "reset_midfill_events",
        64'({exp_rd.size(), exp_fill.size()}), 64'h0);

    run_txn(1, 1, 1, 0, 16'h3038, 16'hC0DE, 16'h0010, 16'h5555);
    repeat (4) @(posedge clk);
    chk(exp_rd.size() + exp_st.size() + exp_fill.size() + exp_tag.size() == 0, "queues_drained",
        64'(exp_rd.size() + exp_st.size() + exp_fill.size() + exp_tag.size()), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
